// File: rtl/flood_pkg.sv
// Shared types and constants for the Flood-It engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flood_pkg;
    localparam int MAX_SIZE = 26;
    localparam int ADDR_W   = 10;
    localparam int COLOR_W  = 3;
    localparam int CELL_W   = COLOR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [4:0] row, input logic [4:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/flood_board_mem.sv
// Board storage: 1024 cells of {flag, color}, engine/load write mux, 5 async neighbourhood reads.
// Latency: write 1 cycle, neighbourhood reads combinational, display read registered (1 cycle).
// Backpressure: none; engine write wins over load write (the two never overlap in practice).
module flood_board_mem
    import flood_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_we,
    input  logic [ADDR_W-1:0]  i_load_addr,
    input  logic [COLOR_W-1:0] i_load_color,
    input  logic               i_eng_we,
    input  logic [ADDR_W-1:0]  i_eng_addr,
    input  logic [CELL_W-1:0]  i_eng_dat,
    input  logic [ADDR_W-1:0]  i_c_addr,
    input  logic [ADDR_W-1:0]  i_u_addr,
    input  logic [ADDR_W-1:0]  i_d_addr,
    input  logic [ADDR_W-1:0]  i_l_addr,
    input  logic [ADDR_W-1:0]  i_r_addr,
    output logic [CELL_W-1:0]  o_c_dat,
    output logic [CELL_W-1:0]  o_u_dat,
    output logic [CELL_W-1:0]  o_d_dat,
    output logic [CELL_W-1:0]  o_l_dat,
    output logic [CELL_W-1:0]  o_r_dat,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [COLOR_W-1:0] o_rd_color
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [CELL_W-1:0]  r_cells [0:DEPTH-1];
    logic [COLOR_W-1:0] r_rd_color;

    always_ff @(posedge i_clk) begin
        if (i_eng_we)
            r_cells[i_eng_addr] <= i_eng_dat;
        else if (i_load_we)
            r_cells[i_load_addr] <= {1'b0, i_load_color};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_rd_color <= '0;
        else
            r_rd_color <= r_cells[i_rd_addr][COLOR_W-1:0];
    end

    assign o_c_dat    = r_cells[i_c_addr];
    assign o_u_dat    = r_cells[i_u_addr];
    assign o_d_dat    = r_cells[i_d_addr];
    assign o_l_dat    = r_cells[i_l_addr];
    assign o_r_dat    = r_cells[i_r_addr];
    assign o_rd_color = r_rd_color;
endmodule

// File: rtl/flood_engine.sv
// Flood-It game engine: seeds the flood at (0,0) on begin-game, grows it by raster sweeps on color select.
// Latency: begin 1 + SIZE^2 + k*SIZE^2 cycles, color change 1 + k*SIZE^2 cycles (k sweeps, last has no growth).
// Backpressure: four-phase handshakes; DONE holds ACK/busy until the request drops.
module flood_engine #(
    parameter int MAX_SIZE = flood_pkg::MAX_SIZE
) (
    input  logic       MASTER_CLOCK,
    input  logic       RESET,
    input  logic [4:0] final_SIZE,
    input  logic [3:0] final_COLOR_NUM,
    input  logic       LOAD_WE,
    input  logic [9:0] LOAD_ADDR,
    input  logic [2:0] LOAD_COLOR,
    input  logic       BEGIN_GAME,
    output logic       ACK_BEGIN_GAME,
    output logic       INITIALIZED,
    input  logic       COLOR_SEL_SIG,
    input  logic [2:0] COLOR_SELECTED,
    output logic       CURRENTLY_CHANGING_COLOR,
    input  logic [9:0] RD_ADDR,
    output logic [2:0] RD_COLOR,
    output logic [9:0] FLOOD_COUNT,
    output logic       WON
);
    import flood_pkg::*;

    state_t             r_state, w_state_nxt;
    logic               r_flow_begin;
    logic [4:0]         r_row, r_col, r_size;
    logic [3:0]         r_color_num;
    logic [COLOR_W-1:0] r_color;
    logic [9:0]         r_changes, r_count, r_flood_count;
    logic               r_won, r_init;

    logic [ADDR_W-1:0]  w_c_addr, w_u_addr, w_d_addr, w_l_addr, w_r_addr;
    logic [CELL_W-1:0]  w_c_dat, w_u_dat, w_d_dat, w_l_dat, w_r_dat;
    logic               w_nbr_flag, w_last_col, w_last_cell, w_sel_noop;
    logic               w_eng_we, w_grow, w_in_flood;
    logic [CELL_W-1:0]  w_eng_dat;
    logic [9:0]         w_changes_nxt, w_count_nxt, w_size_sq;

    // In IDLE the raster position rests at (0,0), so the center port reads the seed cell.
    assign w_c_addr = pack_addr(r_row, r_col);
    assign w_u_addr = pack_addr(r_row - 5'd1, r_col);
    assign w_d_addr = pack_addr(r_row + 5'd1, r_col);
    assign w_l_addr = pack_addr(r_row, r_col - 5'd1);
    assign w_r_addr = pack_addr(r_row, r_col + 5'd1);

    assign w_nbr_flag = ((r_row != 5'd0) && w_u_dat[COLOR_W])
                      | (((r_row + 5'd1) < r_size) && w_d_dat[COLOR_W])
                      | ((r_col != 5'd0) && w_l_dat[COLOR_W])
                      | (((r_col + 5'd1) < r_size) && w_r_dat[COLOR_W]);

    assign w_last_col    = (r_col == r_size - 5'd1);
    assign w_last_cell   = w_last_col && (r_row == r_size - 5'd1);
    assign w_sel_noop    = (COLOR_SELECTED == w_c_dat[COLOR_W-1:0])
                         || ({1'b0, COLOR_SELECTED} >= r_color_num);
    assign w_changes_nxt = (r_changes == 10'h3FF) ? r_changes : r_changes + {9'd0, w_grow};
    assign w_count_nxt   = r_count + {9'd0, w_in_flood};
    assign w_size_sq     = {5'd0, r_size} * {5'd0, r_size};

    always_comb begin
        w_state_nxt = r_state;
        w_eng_we    = 1'b0;
        w_eng_dat   = w_c_dat;
        w_grow      = 1'b0;
        w_in_flood  = 1'b0;
        case (r_state)
            IDLE: begin
                if (BEGIN_GAME)
                    w_state_nxt = CLEAR;
                else if (COLOR_SEL_SIG)
                    w_state_nxt = w_sel_noop ? DONE : SWEEP;
            end
            CLEAR: begin
                w_eng_we  = 1'b1;
                w_eng_dat = {(r_row == 5'd0) && (r_col == 5'd0), w_c_dat[COLOR_W-1:0]};
                if (w_last_cell)
                    w_state_nxt = SWEEP;
            end
            SWEEP: begin
                if (w_c_dat[COLOR_W]) begin
                    w_eng_we   = 1'b1;
                    w_eng_dat  = {1'b1, r_color};
                    w_in_flood = 1'b1;
                end else if ((w_c_dat[COLOR_W-1:0] == r_color) && w_nbr_flag) begin
                    w_eng_we   = 1'b1;
                    w_eng_dat  = {1'b1, r_color};
                    w_grow     = 1'b1;
                    w_in_flood = 1'b1;
                end
                if (w_last_cell && (w_changes_nxt == 10'd0))
                    w_state_nxt = DONE;
            end
            DONE: begin
                if (r_flow_begin ? !BEGIN_GAME : !COLOR_SEL_SIG)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge MASTER_CLOCK) begin
        if (RESET)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge MASTER_CLOCK) begin
        if (RESET) begin
            r_flow_begin  <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_size        <= 5'd2;
            r_color_num   <= 4'd3;
            r_color       <= '0;
            r_changes     <= '0;
            r_count       <= '0;
            r_flood_count <= '0;
            r_won         <= 1'b0;
            r_init        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_row     <= '0;
                    r_col     <= '0;
                    r_changes <= '0;
                    r_count   <= '0;
                    if (BEGIN_GAME) begin
                        r_flow_begin <= 1'b1;
                        r_size       <= (final_SIZE > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : final_SIZE;
                        r_color_num  <= final_COLOR_NUM;
                    end else if (COLOR_SEL_SIG) begin
                        r_flow_begin <= 1'b0;
                        r_color      <= COLOR_SELECTED;
                    end
                end
                CLEAR: begin
                    // The seed cell's color becomes the target of the first sweep.
                    if ((r_row == 5'd0) && (r_col == 5'd0))
                        r_color <= w_c_dat[COLOR_W-1:0];
                    if (w_last_cell) begin
                        r_row <= '0;
                        r_col <= '0;
                    end else if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 5'd1;
                    end else begin
                        r_col <= r_col + 5'd1;
                    end
                end
                SWEEP: begin
                    if (w_last_cell) begin
                        r_row     <= '0;
                        r_col     <= '0;
                        r_changes <= '0;
                        r_count   <= '0;
                        if (w_changes_nxt == 10'd0) begin
                            r_flood_count <= w_count_nxt;
                            r_won         <= (w_count_nxt == w_size_sq);
                            if (r_flow_begin)
                                r_init <= 1'b1;
                        end
                    end else begin
                        r_changes <= w_changes_nxt;
                        r_count   <= w_count_nxt;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 5'd1;
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    flood_board_mem u_mem (
        .i_clk        (MASTER_CLOCK),
        .i_rst        (RESET),
        .i_load_we    (LOAD_WE && (r_state == IDLE)),
        .i_load_addr  (LOAD_ADDR),
        .i_load_color (LOAD_COLOR),
        .i_eng_we     (w_eng_we),
        .i_eng_addr   (w_c_addr),
        .i_eng_dat    (w_eng_dat),
        .i_c_addr     (w_c_addr),
        .i_u_addr     (w_u_addr),
        .i_d_addr     (w_d_addr),
        .i_l_addr     (w_l_addr),
        .i_r_addr     (w_r_addr),
        .o_c_dat      (w_c_dat),
        .o_u_dat      (w_u_dat),
        .o_d_dat      (w_d_dat),
        .o_l_dat      (w_l_dat),
        .o_r_dat      (w_r_dat),
        .i_rd_addr    (RD_ADDR),
        .o_rd_color   (RD_COLOR)
    );

    assign ACK_BEGIN_GAME           = (r_state == DONE) && r_flow_begin;
    assign CURRENTLY_CHANGING_COLOR = (r_state != IDLE) && !r_flow_begin;
    assign INITIALIZED              = r_init;
    assign FLOOD_COUNT              = r_flood_count;
    assign WON                      = r_won;
endmodule

// File: tb/tb_flood_engine.sv
// Directed bench for flood_engine: handshakes, flood growth, no-op selects, reset and priority.
module tb_flood_engine;
    logic       MASTER_CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] final_SIZE = '0;
    logic [3:0] final_COLOR_NUM = '0;
    logic       LOAD_WE = 1'b0;
    logic [9:0] LOAD_ADDR = '0;
    logic [2:0] LOAD_COLOR = '0;
    logic       BEGIN_GAME = 1'b0;
    logic       ACK_BEGIN_GAME;
    logic       INITIALIZED;
    logic       COLOR_SEL_SIG = 1'b0;
    logic [2:0] COLOR_SELECTED = '0;
    logic       CURRENTLY_CHANGING_COLOR;
    logic [9:0] RD_ADDR = '0;
    logic [2:0] RD_COLOR;
    logic [9:0] FLOOD_COUNT;
    logic       WON;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 MASTER_CLOCK = ~MASTER_CLOCK;

    flood_engine dut (
        .MASTER_CLOCK             (MASTER_CLOCK),
        .RESET                    (RESET),
        .final_SIZE               (final_SIZE),
        .final_COLOR_NUM          (final_COLOR_NUM),
        .LOAD_WE                  (LOAD_WE),
        .LOAD_ADDR                (LOAD_ADDR),
        .LOAD_COLOR               (LOAD_COLOR),
        .BEGIN_GAME               (BEGIN_GAME),
        .ACK_BEGIN_GAME           (ACK_BEGIN_GAME),
        .INITIALIZED              (INITIALIZED),
        .COLOR_SEL_SIG            (COLOR_SEL_SIG),
        .COLOR_SELECTED           (COLOR_SELECTED),
        .CURRENTLY_CHANGING_COLOR (CURRENTLY_CHANGING_COLOR),
        .RD_ADDR                  (RD_ADDR),
        .RD_COLOR                 (RD_COLOR),
        .FLOOD_COUNT              (FLOOD_COUNT),
        .WON                      (WON)
    );

    task automatic step(input int n = 1);
        repeat (n) @(negedge MASTER_CLOCK);
    endtask

    task automatic load_cell(input int r, input int c, input logic [2:0] color);
        LOAD_WE    = 1'b1;
        LOAD_ADDR  = {5'(r), 5'(c)};
        LOAD_COLOR = color;
        step();
        LOAD_WE    = 1'b0;
    endtask

    task automatic read_cell(input int r, input int c, output logic [2:0] color);
        RD_ADDR = {5'(r), 5'(c)};
        step();
        color = RD_COLOR;
    endtask

    task automatic load_2x2();
        load_cell(0, 0, 3'd0);
        load_cell(0, 1, 3'd1);
        load_cell(1, 0, 3'd1);
        load_cell(1, 1, 3'd2);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(2);
        n_tests++; if (ACK_BEGIN_GAME !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ACK_BEGIN_GAME); end
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", CURRENTLY_CHANGING_COLOR); end
        n_tests++; if (INITIALIZED !== 1'b0) begin n_fail++; $display("FAIL reset_init: got %b want 0", INITIALIZED); end
        n_tests++; if (FLOOD_COUNT !== 10'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", FLOOD_COUNT); end
        n_tests++; if (WON !== 1'b0) begin n_fail++; $display("FAIL reset_won: got %b want 0", WON); end
        n_tests++; if (RD_COLOR !== 3'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", RD_COLOR); end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_begin_2x2();
        int cyc;
        load_2x2();
        final_SIZE = 5'd2; final_COLOR_NUM = 4'd3;
        BEGIN_GAME = 1'b1;
        cyc = 0;
        do begin step(); cyc++; end while (!ACK_BEGIN_GAME && cyc < 500);
        n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL begin_latency: got %0d want 9", cyc); end
        n_tests++; if (FLOOD_COUNT !== 10'd1) begin n_fail++; $display("FAIL begin_count: got %0d want 1", FLOOD_COUNT); end
        n_tests++; if (INITIALIZED !== 1'b1) begin n_fail++; $display("FAIL begin_init: got %b want 1", INITIALIZED); end
        BEGIN_GAME = 1'b0;
        step();
        n_tests++; if (ACK_BEGIN_GAME !== 1'b0) begin n_fail++; $display("FAIL begin_ack_drop: got %b want 0", ACK_BEGIN_GAME); end
    endtask

    // Raise a color request and wait for FLOOD_COUNT to change, which happens on entry to DONE.
    task automatic test_color_change(input string name, input logic [2:0] color, input int exp_cyc,
                                     input int exp_count, input logic exp_won);
        int cyc;
        logic busy_ok;
        logic [9:0] old_count;
        old_count = FLOOD_COUNT;
        busy_ok = 1'b1;
        COLOR_SEL_SIG = 1'b1; COLOR_SELECTED = color;
        cyc = 0;
        do begin
            step(); cyc++;
            if (CURRENTLY_CHANGING_COLOR !== 1'b1) busy_ok = 1'b0;
        end while (FLOOD_COUNT == old_count && cyc < 2000);
        n_tests++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got low want high during change", name); end
        n_tests++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_cyc); end
        n_tests++; if (FLOOD_COUNT !== 10'(exp_count)) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", name, FLOOD_COUNT, exp_count); end
        n_tests++; if (WON !== exp_won) begin n_fail++; $display("FAIL %s_won: got %b want %b", name, WON, exp_won); end
        step(2);
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b1) begin n_fail++; $display("FAIL %s_hold: got %b want 1", name, CURRENTLY_CHANGING_COLOR); end
        COLOR_SEL_SIG = 1'b0;
        step();
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b0) begin n_fail++; $display("FAIL %s_release: got %b want 0", name, CURRENTLY_CHANGING_COLOR); end
    endtask

    task automatic test_2x2_board(input string name, input logic [2:0] e00, input logic [2:0] e01,
                                  input logic [2:0] e10, input logic [2:0] e11);
        logic [2:0] got;
        logic [2:0] exp [4];
        exp = '{e00, e01, e10, e11};
        for (int i = 0; i < 4; i++) begin
            read_cell(i / 2, i % 2, got);
            n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL %s_cell%0d: got %0d want %0d", name, i, got, exp[i]); end
        end
    endtask

    task automatic test_noop(input string name, input logic [2:0] color);
        logic [9:0] old_count;
        logic [2:0] got;
        old_count = FLOOD_COUNT;
        COLOR_SEL_SIG = 1'b1; COLOR_SELECTED = color;
        step();
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b want 1", name, CURRENTLY_CHANGING_COLOR); end
        step(3);
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b1) begin n_fail++; $display("FAIL %s_hold: got %b want 1", name, CURRENTLY_CHANGING_COLOR); end
        COLOR_SEL_SIG = 1'b0;
        step();
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b0) begin n_fail++; $display("FAIL %s_release: got %b want 0", name, CURRENTLY_CHANGING_COLOR); end
        n_tests++; if (FLOOD_COUNT !== old_count) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", name, FLOOD_COUNT, old_count); end
        read_cell(0, 0, got);
        n_tests++; if (got !== 3'd2) begin n_fail++; $display("FAIL %s_cell00: got %0d want 2", name, got); end
    endtask

    // 6x6 board of color 2 with a path of color 1 that snakes right, down, then back left and down.
    task automatic test_multi_sweep();
        int cyc;
        logic [2:0] got;
        int pr [13] = '{0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 2, 3, 4};
        int pc [13] = '{1, 2, 3, 4, 5, 5, 5, 4, 3, 2, 1, 1, 1};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                load_cell(r, c, (r == 0 && c == 0) ? 3'd0 : 3'd2);
        for (int i = 0; i < 13; i++) load_cell(pr[i], pc[i], 3'd1);
        final_SIZE = 5'd6; final_COLOR_NUM = 4'd3;
        BEGIN_GAME = 1'b1;
        cyc = 0;
        do begin step(); cyc++; end while (!ACK_BEGIN_GAME && cyc < 2000);
        n_tests++; if (cyc !== 73) begin n_fail++; $display("FAIL serp_begin_latency: got %0d want 73", cyc); end
        n_tests++; if (FLOOD_COUNT !== 10'd1) begin n_fail++; $display("FAIL serp_begin_count: got %0d want 1", FLOOD_COUNT); end
        BEGIN_GAME = 1'b0;
        step();
        // Growth stalls once per leftward cell in row 2: six sweeps in total.
        test_color_change("serp", 3'd1, 1 + 6 * 36, 14, 1'b0);
        read_cell(4, 1, got);
        n_tests++; if (got !== 3'd1) begin n_fail++; $display("FAIL serp_cell41: got %0d want 1", got); end
        read_cell(1, 1, got);
        n_tests++; if (got !== 3'd2) begin n_fail++; $display("FAIL serp_cell11: got %0d want 2", got); end
    endtask

    task automatic test_load_ignored();
        int cyc;
        logic [2:0] got;
        COLOR_SEL_SIG = 1'b1; COLOR_SELECTED = 3'd2;
        step(5);
        load_cell(5, 5, 3'd0);
        cyc = 0;
        while (FLOOD_COUNT == 10'd14 && cyc < 2000) begin step(); cyc++; end
        n_tests++; if (FLOOD_COUNT !== 10'd36) begin n_fail++; $display("FAIL ldsweep_count: got %0d want 36", FLOOD_COUNT); end
        n_tests++; if (WON !== 1'b1) begin n_fail++; $display("FAIL ldsweep_won: got %b want 1", WON); end
        COLOR_SEL_SIG = 1'b0;
        step();
        read_cell(5, 5, got);
        n_tests++; if (got !== 3'd2) begin n_fail++; $display("FAIL ldsweep_cell55: got %0d want 2", got); end
    endtask

    task automatic test_reset_mid_sweep();
        COLOR_SEL_SIG = 1'b1; COLOR_SELECTED = 3'd0;
        step(4);
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b1) begin n_fail++; $display("FAIL rstsw_busy_before: got %b want 1", CURRENTLY_CHANGING_COLOR); end
        RESET = 1'b1; COLOR_SEL_SIG = 1'b0;
        step();
        n_tests++; if (CURRENTLY_CHANGING_COLOR !== 1'b0) begin n_fail++; $display("FAIL rstsw_busy: got %b want 0", CURRENTLY_CHANGING_COLOR); end
        n_tests++; if (INITIALIZED !== 1'b0) begin n_fail++; $display("FAIL rstsw_init: got %b want 0", INITIALIZED); end
        n_tests++; if (FLOOD_COUNT !== 10'd0) begin n_fail++; $display("FAIL rstsw_count: got %0d want 0", FLOOD_COUNT); end
        n_tests++; if (WON !== 1'b0) begin n_fail++; $display("FAIL rstsw_won: got %b want 0", WON); end
        n_tests++; if (ACK_BEGIN_GAME !== 1'b0) begin n_fail++; $display("FAIL rstsw_ack: got %b want 0", ACK_BEGIN_GAME); end
        n_tests++; if (RD_COLOR !== 3'd0) begin n_fail++; $display("FAIL rstsw_rd: got %0d want 0", RD_COLOR); end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_priority();
        int cyc;
        logic busy_seen;
        load_2x2();
        final_SIZE = 5'd2; final_COLOR_NUM = 4'd3;
        BEGIN_GAME = 1'b1; COLOR_SEL_SIG = 1'b1; COLOR_SELECTED = 3'd1;
        busy_seen = 1'b0;
        cyc = 0;
        do begin
            step(); cyc++;
            if (CURRENTLY_CHANGING_COLOR !== 1'b0) busy_seen = 1'b1;
        end while (!ACK_BEGIN_GAME && cyc < 500);
        n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL prio_latency: got %0d want 9", cyc); end
        n_tests++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got high want low"); end
        n_tests++; if (FLOOD_COUNT !== 10'd1) begin n_fail++; $display("FAIL prio_count: got %0d want 1", FLOOD_COUNT); end
        BEGIN_GAME = 1'b0; COLOR_SEL_SIG = 1'b0;
        step();
        test_2x2_board("prio", 3'd0, 3'd1, 3'd1, 3'd2);
    endtask

    initial begin
        test_reset();
        test_begin_2x2();
        test_color_change("sel1", 3'd1, 9, 3, 1'b0);
        test_2x2_board("sel1", 3'd1, 3'd1, 3'd1, 3'd2);
        test_color_change("sel2", 3'd2, 9, 4, 1'b1);
        test_2x2_board("sel2", 3'd2, 3'd2, 3'd2, 3'd2);
        test_noop("noop_same", 3'd2);
        test_noop("noop_range", 3'd5);
        test_multi_sweep();
        test_load_ignored();
        test_reset_mid_sweep();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
